// File: rtl/bird_motion.sv
// Vertical bird physics: flap edge detect, gravity/flap velocity, floor/ceiling clamp, freeze on collision.
// Optional TERMINAL_VELOCITY_EN caps downward velocity at MAX_FALL; otherwise the VEL_W signed limit applies.
module bird_motion #(
  parameter int BIRD_X    = 100,
  parameter int BIRD_SIZE = 16,
  parameter int START_Y   = 232,
  parameter int SCREEN_H  = 480,
  parameter int GRAVITY   = 1,
  parameter int FLAP_VEL  = 6,
  parameter int MAX_FALL  = 8,
  parameter int VEL_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flap,
  input  logic       tick,
  input  logic       collision,
  output logic [8:0] birdTop,
  output logic [8:0] birdBot,
  output logic [8:0] birdLeft,
  output logic [8:0] birdRight,
  output logic       alive,
  output logic       started
);

`ifdef TERMINAL_VELOCITY_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  localparam int VEL_HI = 2 ** (VEL_W - 1) - 1;
  localparam int VEL_LO = -(2 ** (VEL_W - 1));
  localparam int VMAX   = CAP_EN ? MAX_FALL : VEL_HI;
  localparam int Y_MAX  = SCREEN_H - BIRD_SIZE;
  localparam logic signed [VEL_W-1:0] FLAP_V = VEL_W'(-FLAP_VEL);

  typedef enum logic [1:0] {READY, FLYING, DEAD} state_t;

  state_t                    state, state_nxt;
  logic [8:0]                y, y_nxt;
  logic signed [VEL_W-1:0]   vel, vel_nxt, vel_new, vel_sat;
  logic signed [VEL_W:0]     vel_inc;
  logic signed [10:0]        sum;
  logic                      pending, pending_nxt;
  logic                      flap_d;
  logic                      edge_det;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= READY;
      y       <= 9'(START_Y);
      vel     <= '0;
      pending <= 1'b0;
      flap_d  <= 1'b0;
    end else begin
      state   <= state_nxt;
      y       <= y_nxt;
      vel     <= vel_nxt;
      pending <= pending_nxt;
      flap_d  <= flap;
    end
  end

  always_comb begin
    state_nxt   = state;
    y_nxt       = y;
    vel_nxt     = vel;
    pending_nxt = pending;
    edge_det    = flap & ~flap_d;

    // One extra bit so the gravity add cannot wrap before saturation.
    vel_inc = $signed({vel[VEL_W-1], vel}) + $signed((VEL_W+1)'(GRAVITY));
    if (vel_inc > VMAX)
      vel_sat = VEL_W'(VMAX);
    else if (vel_inc < VEL_LO)
      vel_sat = VEL_W'(VEL_LO);
    else
      vel_sat = vel_inc[VEL_W-1:0];

    // A flap edge coincident with the tick is consumed by that tick.
    vel_new = (pending | edge_det) ? FLAP_V : vel_sat;
    sum     = $signed({2'b00, y}) + $signed({{(11-VEL_W){vel_new[VEL_W-1]}}, vel_new});

    case (state)
      READY: begin
        if (edge_det) begin
          state_nxt   = FLYING;
          pending_nxt = 1'b1;
        end
      end
      FLYING: begin
        if (collision) begin
          state_nxt = DEAD;
        end else if (tick) begin
          pending_nxt = 1'b0;
          if (sum < 0) begin
            y_nxt   = '0;
            vel_nxt = '0;
          end else if (sum > Y_MAX) begin
            y_nxt   = 9'(Y_MAX);
            vel_nxt = '0;
          end else begin
            y_nxt   = sum[8:0];
            vel_nxt = vel_new;
          end
        end else if (edge_det) begin
          pending_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign birdTop   = y;
  assign birdBot   = y + 9'(BIRD_SIZE - 1);
  assign birdLeft  = 9'(BIRD_X);
  assign birdRight = 9'(BIRD_X + BIRD_SIZE - 1);
  assign alive     = (state != DEAD);
  assign started   = (state != READY);

endmodule

// File: tb/tb_bird_motion.sv
// Scoreboarded bench for bird_motion: a reference model pushes {top,alive,started} per cycle.
module tb_bird_motion;

`ifdef TERMINAL_VELOCITY_EN
  localparam int VCAP     = 8;
  localparam int EXP_LAST = 8;
`else
  localparam int VCAP     = 31;
  localparam int EXP_LAST = 10;
`endif

  localparam int APEX [7] = '{226, 221, 217, 214, 212, 211, 211};

  logic       clk;
  logic       reset;
  logic       flap;
  logic       tick;
  logic       collision;
  logic [8:0] birdTop, birdBot, birdLeft, birdRight;
  logic       alive, started;

  int total;
  int passed;

  int m_st, m_y, m_vel;
  bit m_pend, m_fd;
  logic [10:0] sb [$];
  logic [10:0] exp_v, got_v;

  bird_motion dut (
    .clk(clk), .reset(reset), .flap(flap), .tick(tick), .collision(collision),
    .birdTop(birdTop), .birdBot(birdBot), .birdLeft(birdLeft), .birdRight(birdRight),
    .alive(alive), .started(started)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step(input bit r, input bit f, input bit t, input bit c);
    bit e;
    int nv, s;
    if (r) begin
      m_st = 0; m_y = 232; m_vel = 0; m_pend = 0; m_fd = 0;
    end else begin
      e = f && !m_fd;
      m_fd = f;
      if (m_st == 0) begin
        if (e) begin m_st = 1; m_pend = 1; end
      end else if (m_st == 1) begin
        if (c) m_st = 2;
        else if (t) begin
          nv = (m_pend || e) ? -6 : ((m_vel + 1 > VCAP) ? VCAP : m_vel + 1);
          m_pend = 0;
          s = m_y + nv;
          if (s < 0) begin m_y = 0; m_vel = 0; end
          else if (s > 464) begin m_y = 464; m_vel = 0; end
          else begin m_y = s; m_vel = nv; end
        end else if (e) m_pend = 1;
      end
    end
    sb.push_back({9'(m_y), m_st != 2, m_st != 0});
  endtask

  task automatic step(input bit r, input bit f, input bit t, input bit c);
    @(negedge clk);
    reset = r; flap = f; tick = t; collision = c;
    model_step(r, f, t, c);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    total++; if (birdTop !== 9'd232) $display("FAIL reset_top got %0d exp 232", birdTop); else passed++;
    total++; if (birdBot !== 9'd247) $display("FAIL reset_bot got %0d exp 247", birdBot); else passed++;
    total++; if (birdLeft !== 9'd100) $display("FAIL reset_left got %0d exp 100", birdLeft); else passed++;
    total++; if (birdRight !== 9'd115) $display("FAIL reset_right got %0d exp 115", birdRight); else passed++;
    total++; if ({alive, started} !== 2'b10) $display("FAIL reset_flags got %b exp 10", {alive, started}); else passed++;
    exp_v = sb.pop_front();
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, (i == 4));
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL ready_idle[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
    end
    total++; if (birdTop !== 9'd232 || birdBot !== 9'd247) $display("FAIL ready_hold got %0d/%0d exp 232/247", birdTop, birdBot); else passed++;
  endtask

  task automatic test_flap_hold();
    step(0, 1, 0, 0);
    exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
    total++; if (got_v !== exp_v) $display("FAIL start_edge got %h exp %h", got_v, exp_v); else passed++;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 1, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL hold_tick[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
      if (i < 7) begin
        total++; if (birdTop !== 9'(APEX[i])) $display("FAIL apex[%0d] got %0d exp %0d", i, birdTop, APEX[i]); else passed++;
      end
      step(0, 1, 0, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL hold_idle[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
    end
    total++; if (started !== 1'b1) $display("FAIL hold_started got %b exp 1", started); else passed++;
  endtask

  task automatic test_terminal_floor();
    int prev, delta;
    step(1, 0, 0, 0); exp_v = sb.pop_front();
    step(0, 1, 0, 0); exp_v = sb.pop_front();
    step(0, 0, 0, 0); exp_v = sb.pop_front();
    prev = 232; delta = 0;
    for (int i = 0; i < 17; i++) begin
      step(0, 0, 1, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL fall_tick[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
      delta = int'(birdTop) - prev;
      prev = int'(birdTop);
    end
    total++; if (delta !== EXP_LAST) $display("FAIL fall_delta got %0d exp %0d", delta, EXP_LAST); else passed++;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 1, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL floor_tick[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
    end
    total++; if (birdTop !== 9'd464 || birdBot !== 9'd479) $display("FAIL floor_pin got %0d/%0d exp 464/479", birdTop, birdBot); else passed++;
  endtask

  task automatic test_ceiling();
    for (int i = 0; i < 85; i++) begin
      step(0, 1, 1, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL ceil_flap[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
      step(0, 0, 0, 0);
      exp_v = sb.pop_front();
    end
    total++; if (birdTop !== 9'd0) $display("FAIL ceil_pin got %0d exp 0", birdTop); else passed++;
    step(0, 0, 1, 0);
    exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
    total++; if (got_v !== exp_v) $display("FAIL ceil_release got %h exp %h", got_v, exp_v); else passed++;
    total++; if (birdTop !== 9'd1) $display("FAIL ceil_gravity got %0d exp 1", birdTop); else passed++;
  endtask

  task automatic test_back_to_back();
    step(1, 0, 0, 0); exp_v = sb.pop_front();
    step(0, 1, 0, 0); exp_v = sb.pop_front();
    step(0, 0, 1, 0); exp_v = sb.pop_front();
    total++; if (birdTop !== 9'd226) $display("FAIL b2b_first got %0d exp 226", birdTop); else passed++;
    step(0, 1, 0, 0); exp_v = sb.pop_front();
    step(0, 0, 0, 0); exp_v = sb.pop_front();
    step(0, 1, 0, 0); exp_v = sb.pop_front();
    step(0, 0, 1, 0);
    exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
    total++; if (got_v !== exp_v) $display("FAIL b2b_sb got %h exp %h", got_v, exp_v); else passed++;
    total++; if (birdTop !== 9'd220) $display("FAIL b2b_collapse got %0d exp 220", birdTop); else passed++;
    step(0, 0, 1, 0); exp_v = sb.pop_front();
    total++; if (birdTop !== 9'd215) $display("FAIL b2b_next got %0d exp 215", birdTop); else passed++;
  endtask

  task automatic test_collision();
    step(1, 0, 0, 0); exp_v = sb.pop_front();
    step(0, 0, 0, 1); exp_v = sb.pop_front();
    total++; if (alive !== 1'b1 || started !== 1'b0) $display("FAIL ready_coll got %b%b exp 10", alive, started); else passed++;
    step(0, 1, 0, 0); exp_v = sb.pop_front();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0); exp_v = sb.pop_front();
    end
    step(0, 0, 1, 1);
    exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
    total++; if (got_v !== exp_v) $display("FAIL coll_sb got %h exp %h", got_v, exp_v); else passed++;
    total++; if (birdTop !== 9'd217 || alive !== 1'b0 || started !== 1'b1) $display("FAIL coll_freeze got %0d %b%b exp 217 01", birdTop, alive, started); else passed++;
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 0); exp_v = sb.pop_front();
      step(0, 0, 1, 0);
      exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
      total++; if (got_v !== exp_v) $display("FAIL dead_tick[%0d] got %h exp %h", i, got_v, exp_v); else passed++;
    end
    total++; if (birdTop !== 9'd217 || alive !== 1'b0) $display("FAIL dead_hold got %0d %b exp 217 0", birdTop, alive); else passed++;
    step(1, 0, 0, 0);
    exp_v = sb.pop_front(); got_v = {birdTop, alive, started};
    total++; if (got_v !== exp_v) $display("FAIL dead_reset_sb got %h exp %h", got_v, exp_v); else passed++;
    total++; if (birdTop !== 9'd232 || {alive, started} !== 2'b10) $display("FAIL dead_reset got %0d %b%b exp 232 10", birdTop, alive, started); else passed++;
  endtask

  initial begin
    total = 0; passed = 0;
    reset = 1'b1; flap = 1'b0; tick = 1'b0; collision = 1'b0;
    test_reset();
    test_flap_hold();
    test_terminal_floor();
    test_ceiling();
    test_back_to_back();
    test_collision();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
Name: bird_motion

Overview:
- Vertical physics engine for the player bird.
- Consumes the synchronized flap level from the user-input stage and a per-frame physics strobe.
- Produces the bird bounding box (birdTop/birdBot/birdLeft/birdRight) that feeds the collision unit and pixel-colouring logic.
- Freezes the bird once the collision unit reports a hit.

Parameters:
- BIRD_X, 100, left column of bird (fixed horizontal position)
- BIRD_SIZE, 16, bird width and height in pixels
- START_Y, 232, birdTop value after reset
- SCREEN_H, 480, visible rows; floor limit is SCREEN_H-BIRD_SIZE
- GRAVITY, 1, downward velocity added per tick
- FLAP_VEL, 6, magnitude of upward velocity loaded on flap
- MAX_FALL, 8, terminal downward velocity (used only with the optional feature)
- VEL_W, 6, signed velocity register width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flap  in  1  synchronized user press level; high while key is held
- tick  in  1  single-cycle physics-step strobe, one per frame
- collision  in  1  level from collision unit
- birdTop  out  9  upper edge row of bird (numerically smaller y; y grows downward)
- birdBot  out  9  birdTop+BIRD_SIZE-1
- birdLeft  out  9  BIRD_X
- birdRight  out  9  BIRD_X+BIRD_SIZE-1
- alive  out  1  high in READY and FLYING
- started  out  1  high in FLYING and DEAD

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset, including mid-flight: state=READY, y=START_Y, vel=0, pending=0, flap_d=0. Outputs become birdTop=232, birdBot=247, birdLeft=100, birdRight=115, alive=1, started=0 on the cycle after reset is sampled.
- Flap edge: flap_d is registered flap. edge = flap & ~flap_d. Holding the key yields exactly one edge.
- READY:
  - Bird is held still; tick and collision are ignored.
  - An edge moves to FLYING and sets pending=1.
- FLYING, on an edge: set pending=1. Multiple edges between ticks collapse to one.
- FLYING, on tick with no collision that cycle:
  - vel_new = pending ? -FLAP_VEL : sat(vel+GRAVITY); pending cleared.
  - An edge arriving in the same cycle as the tick is consumed by that tick.
  - sum = y + vel_new, computed signed 11-bit.
  - sum<0: y=0, vel=0.
  - sum>SCREEN_H-BIRD_SIZE: y=SCREEN_H-BIRD_SIZE, vel=0.
  - Otherwise: y=sum, vel=vel_new.
- FLYING, on collision=1 in any cycle: go to DEAD. Collision has priority over a coincident tick; no position update occurs that cycle.
- DEAD:
  - y and vel are frozen; flap, tick and collision are ignored.
  - Exit only via reset.
- Outputs are registered or derived from registers only; birdTop changes one cycle after the tick.
- Velocity saturates at the signed VEL_W limits (+31/-32); it never wraps.

Optional Feature:
- Macro: TERMINAL_VELOCITY_EN.
- Defined: sat() clamps downward velocity at +MAX_FALL (8).
- Undefined: downward velocity grows until the VEL_W saturation limit (+31). The floor clamp still applies.

Test Plan:
- Reset, then 10 ticks with no flap -> birdTop stays 232, birdBot 247, alive=1, started=0.
- Flap edge, then ticks 1..7 -> birdTop 226, 221, 217, 214, 212, 211, 211; started=1.
- Flap held high across 20 ticks after start -> exactly one impulse; birdTop follows the sequence above, then falls with deltas 1, 2, 3...
- TERMINAL_VELOCITY_EN defined, long fall -> per-tick delta reaches 8 and stays 8. Undefined -> delta keeps growing past 8.
- Free fall to floor -> birdTop pins at 464 with vel reset each tick. Repeated flaps near the top -> birdTop pins at 0.
- Collision pulse coincident with a tick in FLYING -> birdTop unchanged, alive=0. Later flaps and ticks cause no change. Reset -> READY, birdTop 232.
